// File: rtl/onehot_scan_pkg.sv
// Shared definitions for the one-hot scan decoder: mode encodings and FSM states.
package onehot_scan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_BLANK  = 2'd3
  } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational N-to-OUTS one-hot decoder with enable. Indices at or above
// OUTS decode to all zeros, so a sparse output count needs no extra masking.
module onehot_dec
  import onehot_scan_pkg::*;
#(
  parameter int N    = 3,
  parameter int OUTS = 8
) (
  input  logic            en,
  input  logic [N-1:0]    idx,
  output logic [OUTS-1:0] y
);

  // One bit per output; the range check falls out of the loop bound.
  always_comb begin
    y = '0;
    for (int i = 0; i < OUTS; i++) begin
      y[i] = en && (int'(idx) == i);
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder with a direct (valid/ready load) mode and a
// scan mode that walks every output with a programmable dwell time.
// Optional build macro ONEHOT_SCAN_BLANK_EN adds a break-before-make blank
// cycle on every change of the held index.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | en low: y forced to zero, index and dwell counter frozen
// ST_DIRECT | en high, mode direct: accepts loads, y follows cur_idx
// ST_SCAN   | en high, mode scan: dwell counter runs, index advances
// ST_BLANK  | one cycle of y=0 after an index change (blank builds only)
//
// The operating state is decoded from en/mode in the current cycle so that
// load_ready reflects a mode change immediately; state_q keeps the previous
// cycle's state to detect entry into scan from direct.
module onehot_scan_decoder
  import onehot_scan_pkg::*;
#(
  parameter int N       = 3,
  parameter int OUTS    = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               load_valid,
  input  logic [N-1:0]       load_idx,
  output logic               load_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUTS-1:0]    y,
  output logic [N-1:0]       cur_idx,
  output logic               wrap
);

  localparam int LAST = OUTS - 1;

  state_t               state_q, state_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d, cnt_base;
  logic [N-1:0]         idx_d, idx_adv;
  logic [OUTS-1:0]      y_d;
  logic                 wrap_d, show_d, take, at_top, dwell_hit;
  logic                 blank_q, blank_d;
  logic                 wrap_pend_q, wrap_pend_d;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode: en and mode pick the state every cycle, a pending blank overrides.
  always_comb begin
    state_d = ST_IDLE;
    if (en) begin
      if (blank_q)                 state_d = ST_BLANK;
      else if (mode == MODE_SCAN)  state_d = ST_SCAN;
      else                         state_d = ST_DIRECT;
    end
  end

  // FSM outputs: ready only while directly loadable; held high through reset.
  always_comb begin
    load_ready = !rst_n || (state_d == ST_DIRECT);
  end

  // Datapath next values for index, dwell counter, wrap and output enable.
  always_comb begin
    take      = load_valid && (state_d == ST_DIRECT);
    at_top    = int'(cur_idx) >= LAST;
    idx_adv   = at_top ? '0 : cur_idx + N'(1);
    cnt_base  = (state_q == ST_DIRECT) ? '0 : cnt_q;
    dwell_hit = cnt_base >= dwell;

    idx_d       = cur_idx;
    cnt_d       = cnt_q;
    wrap_d      = 1'b0;
    show_d      = 1'b0;
    blank_d     = 1'b0;
    wrap_pend_d = 1'b0;

    case (state_d)
      ST_DIRECT: begin
        show_d = 1'b1;
        if (take) begin
          idx_d = load_idx;
`ifdef ONEHOT_SCAN_BLANK_EN
          if (load_idx != cur_idx) begin
            blank_d = 1'b1;
            show_d  = 1'b0;
          end
`endif
        end
      end
      ST_SCAN: begin
        show_d = 1'b1;
        if (dwell_hit) begin
          cnt_d = '0;
          idx_d = idx_adv;
`ifdef ONEHOT_SCAN_BLANK_EN
          blank_d     = 1'b1;
          show_d      = 1'b0;
          wrap_pend_d = at_top;
`else
          wrap_d      = at_top;
`endif
        end else begin
          cnt_d = cnt_base + DWELL_W'(1);
        end
      end
      ST_BLANK: begin
        // The blank cycle is part of the dwell; wrap lines up with index 0 appearing.
        show_d = 1'b1;
        wrap_d = wrap_pend_q;
        cnt_d  = (mode == MODE_SCAN) ? cnt_q + DWELL_W'(1) : '0;
      end
      default: ;
    endcase
  end

  onehot_dec #(
    .N    (N),
    .OUTS (OUTS)
  ) u_dec (
    .en  (show_d),
    .idx (idx_d),
    .y   (y_d)
  );

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y           <= '0;
      cur_idx     <= '0;
      wrap        <= 1'b0;
      cnt_q       <= '0;
      blank_q     <= 1'b0;
      wrap_pend_q <= 1'b0;
    end else begin
      y           <= y_d;
      cur_idx     <= idx_d;
      wrap        <= wrap_d;
      cnt_q       <= cnt_d;
      blank_q     <= blank_d;
      wrap_pend_q <= wrap_pend_d;
    end
  end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Self-checking bench for onehot_scan_decoder: an 8-output instance and a
// 5-output instance share stimulus; expected results are queued per step.
module tb_onehot_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, load_valid;
  logic [2:0] load_idx;
  logic [7:0] dwell;

  logic       load_ready, wrap;
  logic [7:0] y;
  logic [2:0] cur_idx;
  logic       load_ready_b, wrap_b;
  logic [4:0] y_b;
  logic [2:0] cur_idx_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
    logic       rdy;
    logic       chk_b;
    logic [4:0] yb;
    logic [2:0] idxb;
    logic       wrapb;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       en;
    logic       mode;
    logic       lv;
    logic [2:0] lidx;
    logic [7:0] dw;
    exp_t       e;
  } step_t;

  exp_t sb[$];

  onehot_scan_decoder #(.N(3), .OUTS(8), .DWELL_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .load_valid(load_valid), .load_idx(load_idx), .load_ready(load_ready),
    .dwell(dwell), .y(y), .cur_idx(cur_idx), .wrap(wrap)
  );

  onehot_scan_decoder #(.N(3), .OUTS(5), .DWELL_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .load_valid(load_valid), .load_idx(load_idx), .load_ready(load_ready_b),
    .dwell(dwell), .y(y_b), .cur_idx(cur_idx_b), .wrap(wrap_b)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic step_t st(int r, int e_n, int m, int lv, int li, int dw,
                               int ey, int ei, int ew, int er);
    step_t s;
    s.rst = 1'(r);   s.en = 1'(e_n); s.mode = 1'(m); s.lv = 1'(lv);
    s.lidx = 3'(li); s.dw = 8'(dw);
    s.e.y = 8'(ey);  s.e.idx = 3'(ei); s.e.wrap = 1'(ew); s.e.rdy = 1'(er);
    s.e.chk_b = 1'b0; s.e.yb = '0; s.e.idxb = '0; s.e.wrapb = 1'b0;
    return s;
  endfunction

  function automatic step_t stb(int r, int e_n, int m, int lv, int li, int dw,
                                int ey, int ei, int ew, int er,
                                int yb, int ib, int wb);
    step_t s;
    s = st(r, e_n, m, lv, li, dw, ey, ei, ew, er);
    s.e.chk_b = 1'b1; s.e.yb = 5'(yb); s.e.idxb = 3'(ib); s.e.wrapb = 1'(wb);
    return s;
  endfunction

  task automatic apply(input step_t s);
    rst_n = s.rst; en = s.en; mode = s.mode;
    load_valid = s.lv; load_idx = s.lidx; dwell = s.dw;
  endtask

  task automatic test_reset();
    step_t s[$];
    exp_t  e;
    repeat (3) s.push_back(stb(0,1,1,1,5,0, 8'h00,0,0,1, 0,0,0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i].e);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (y !== e.y || cur_idx !== e.idx || wrap !== e.wrap || load_ready !== e.rdy) begin
        errors++;
        $display("FAIL reset[%0d]: got y=%h idx=%0d wrap=%b rdy=%b, expected y=%h idx=%0d wrap=%b rdy=%b",
                 i, y, cur_idx, wrap, load_ready, e.y, e.idx, e.wrap, e.rdy);
      end
      if (e.chk_b) begin
        checks++;
        if (y_b !== e.yb || cur_idx_b !== e.idxb || wrap_b !== e.wrapb || load_ready_b !== e.rdy) begin
          errors++;
          $display("FAIL reset_b[%0d]: got y=%h idx=%0d wrap=%b rdy=%b, expected y=%h idx=%0d wrap=%b rdy=%b",
                   i, y_b, cur_idx_b, wrap_b, load_ready_b, e.yb, e.idxb, e.wrapb, e.rdy);
        end
      end
    end
  endtask

  task automatic test_direct();
    step_t s[$];
    exp_t  e;
    s.push_back(stb(1,1,0,1,5,0, 8'h20,5,0,1, 0,5,0));
    s.push_back(stb(1,1,0,1,7,0, 8'h80,7,0,1, 0,7,0));
    s.push_back(stb(1,1,0,0,2,0, 8'h80,7,0,1, 0,7,0));
    s.push_back(stb(1,1,0,1,0,0, 8'h01,0,0,1, 1,0,0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i].e);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (y !== e.y || cur_idx !== e.idx || wrap !== e.wrap || load_ready !== e.rdy) begin
        errors++;
        $display("FAIL direct[%0d]: got y=%h idx=%0d wrap=%b rdy=%b, expected y=%h idx=%0d wrap=%b rdy=%b",
                 i, y, cur_idx, wrap, load_ready, e.y, e.idx, e.wrap, e.rdy);
      end
      if (e.chk_b) begin
        checks++;
        if (y_b !== e.yb || cur_idx_b !== e.idxb || wrap_b !== e.wrapb || load_ready_b !== e.rdy) begin
          errors++;
          $display("FAIL direct_b[%0d]: got y=%h idx=%0d wrap=%b rdy=%b, expected y=%h idx=%0d wrap=%b rdy=%b",
                   i, y_b, cur_idx_b, wrap_b, load_ready_b, e.yb, e.idxb, e.wrapb, e.rdy);
        end
      end
    end
  endtask

  // Scan from index 6 with dwell 2, wrap to 0, then dwell 0 advancing every cycle.
  task automatic test_scan();
    step_t s[$];
    exp_t  e;
    s.push_back(st(1,1,0,1,6,2, 8'h40,6,0,1));
    s.push_back(st(1,1,1,0,6,2, 8'h40,6,0,0));
    s.push_back(st(1,1,1,0,6,2, 8'h40,6,0,0));
    s.push_back(st(1,1,1,0,6,2, 8'h80,7,0,0));
    s.push_back(st(1,1,1,0,6,2, 8'h80,7,0,0));
    s.push_back(st(1,1,1,0,6,2, 8'h80,7,0,0));
    s.push_back(st(1,1,1,0,6,2, 8'h01,0,1,0));
    s.push_back(st(1,1,1,0,6,0, 8'h02,1,0,0));
    s.push_back(st(1,1,1,0,6,0, 8'h04,2,0,0));
    s.push_back(st(1,1,1,0,6,0, 8'h08,3,0,0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i].e);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (y !== e.y || cur_idx !== e.idx || wrap !== e.wrap || load_ready !== e.rdy) begin
        errors++;
        $display("FAIL scan[%0d]: got y=%h idx=%0d wrap=%b rdy=%b, expected y=%h idx=%0d wrap=%b rdy=%b",
                 i, y, cur_idx, wrap, load_ready, e.y, e.idx, e.wrap, e.rdy);
      end
    end
  endtask

  // Index 3, counter 1, en low for 4 cycles, then resume.
  task automatic test_enable_freeze();
    step_t s[$];
    exp_t  e;
    s.push_back(st(1,1,1,0,0,2, 8'h08,3,0,0));
    repeat (4) s.push_back(st(1,0,1,0,0,2, 8'h00,3,0,0));
    s.push_back(st(1,1,1,0,0,2, 8'h08,3,0,0));
    s.push_back(st(1,1,1,0,0,2, 8'h10,4,0,0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i].e);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (y !== e.y || cur_idx !== e.idx || wrap !== e.wrap || load_ready !== e.rdy) begin
        errors++;
        $display("FAIL freeze[%0d]: got y=%h idx=%0d wrap=%b rdy=%b, expected y=%h idx=%0d wrap=%b rdy=%b",
                 i, y, cur_idx, wrap, load_ready, e.y, e.idx, e.wrap, e.rdy);
      end
    end
  endtask

  // Scan->direct->scan with a load offered on the switch cycle, then loads while disabled.
  task automatic test_mode_switch();
    step_t s[$];
    exp_t  e;
    s.push_back(st(1,1,1,0,0,2, 8'h10,4,0,0));
    s.push_back(st(1,1,0,0,0,2, 8'h10,4,0,1));
    s.push_back(st(1,1,1,1,1,2, 8'h10,4,0,0));
    s.push_back(st(1,1,1,0,1,2, 8'h10,4,0,0));
    s.push_back(st(1,1,1,0,1,2, 8'h20,5,0,0));
    s.push_back(st(1,0,0,1,6,2, 8'h00,5,0,0));
    s.push_back(st(1,1,0,0,6,2, 8'h20,5,0,1));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i].e);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (y !== e.y || cur_idx !== e.idx || wrap !== e.wrap || load_ready !== e.rdy) begin
        errors++;
        $display("FAIL mode_switch[%0d]: got y=%h idx=%0d wrap=%b rdy=%b, expected y=%h idx=%0d wrap=%b rdy=%b",
                 i, y, cur_idx, wrap, load_ready, e.y, e.idx, e.wrap, e.rdy);
      end
    end
  endtask

  // Index 6 is out of range for the 5-output instance: y=0, next advance wraps to 0.
  task automatic test_out_of_range();
    step_t s[$];
    exp_t  e;
    s.push_back(stb(1,1,0,1,6,1, 8'h40,6,0,1, 5'h00,6,0));
    s.push_back(stb(1,1,1,0,6,1, 8'h40,6,0,0, 5'h00,6,0));
    s.push_back(stb(1,1,1,0,6,1, 8'h80,7,0,0, 5'h01,0,1));
    s.push_back(stb(1,1,1,0,6,1, 8'h80,7,0,0, 5'h01,0,0));
    s.push_back(stb(1,1,1,0,6,1, 8'h01,0,1,0, 5'h02,1,0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i].e);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (y !== e.y || cur_idx !== e.idx || wrap !== e.wrap || load_ready !== e.rdy) begin
        errors++;
        $display("FAIL range[%0d]: got y=%h idx=%0d wrap=%b rdy=%b, expected y=%h idx=%0d wrap=%b rdy=%b",
                 i, y, cur_idx, wrap, load_ready, e.y, e.idx, e.wrap, e.rdy);
      end
      if (e.chk_b) begin
        checks++;
        if (y_b !== e.yb || cur_idx_b !== e.idxb || wrap_b !== e.wrapb || load_ready_b !== e.rdy) begin
          errors++;
          $display("FAIL range_b[%0d]: got y=%h idx=%0d wrap=%b rdy=%b, expected y=%h idx=%0d wrap=%b rdy=%b",
                   i, y_b, cur_idx_b, wrap_b, load_ready_b, e.yb, e.idxb, e.wrapb, e.rdy);
        end
      end
    end
  endtask

  // Random loads every cycle, then reset in the middle of a scan.
  task automatic test_back_to_back();
    step_t s[$];
    exp_t  e;
    int    k;
    for (int n = 0; n < 10; n++) begin
      k = int'($urandom_range(0, 7));
      s.push_back(stb(1,1,0,1,k,2, 1 << k,k,0,1, (k < 5) ? (1 << k) : 0,k,0));
    end
    s.push_back(stb(1,1,1,0,0,3, 1 << k,k,0,0, (k < 5) ? (1 << k) : 0,k,0));
    s.push_back(stb(0,1,1,0,0,3, 8'h00,0,0,1, 5'h00,0,0));
    s.push_back(stb(1,1,1,0,0,0, 8'h02,1,0,0, 5'h02,1,0));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i].e);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (y !== e.y || cur_idx !== e.idx || wrap !== e.wrap || load_ready !== e.rdy) begin
        errors++;
        $display("FAIL b2b[%0d]: got y=%h idx=%0d wrap=%b rdy=%b, expected y=%h idx=%0d wrap=%b rdy=%b",
                 i, y, cur_idx, wrap, load_ready, e.y, e.idx, e.wrap, e.rdy);
      end
      if (e.chk_b) begin
        checks++;
        if (y_b !== e.yb || cur_idx_b !== e.idxb || wrap_b !== e.wrapb || load_ready_b !== e.rdy) begin
          errors++;
          $display("FAIL b2b_b[%0d]: got y=%h idx=%0d wrap=%b rdy=%b, expected y=%h idx=%0d wrap=%b rdy=%b",
                   i, y_b, cur_idx_b, wrap_b, load_ready_b, e.yb, e.idxb, e.wrapb, e.rdy);
        end
      end
    end
  endtask

`ifdef ONEHOT_SCAN_BLANK_EN
  // Load 2 then 4 with a blank cycle between, then reload 4 with no blank.
  task automatic test_blank();
    step_t s[$];
    exp_t  e;
    s.push_back(st(1,1,0,0,0,0, 8'h01,0,0,1));
    s.push_back(st(1,1,0,1,2,0, 8'h00,2,0,0));
    s.push_back(st(1,1,0,1,4,0, 8'h04,2,0,1));
    s.push_back(st(1,1,0,1,4,0, 8'h00,4,0,0));
    s.push_back(st(1,1,0,0,4,0, 8'h10,4,0,1));
    s.push_back(st(1,1,0,1,4,0, 8'h10,4,0,1));
    foreach (s[i]) begin
      apply(s[i]); sb.push_back(s[i].e);
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (y !== e.y || cur_idx !== e.idx || wrap !== e.wrap || load_ready !== e.rdy) begin
        errors++;
        $display("FAIL blank[%0d]: got y=%h idx=%0d wrap=%b rdy=%b, expected y=%h idx=%0d wrap=%b rdy=%b",
                 i, y, cur_idx, wrap, load_ready, e.y, e.idx, e.wrap, e.rdy);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 1'b1;
    load_valid = 1'b0; load_idx = '0; dwell = '0;
    test_reset();
`ifdef ONEHOT_SCAN_BLANK_EN
    test_blank();
`else
    test_direct();
    test_scan();
    test_enable_freeze();
    test_mode_switch();
    test_out_of_range();
    test_back_to_back();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_scan_decoder.md
Name: onehot_scan_decoder

Overview:
Parametrised, registered N-to-OUTS one-hot decoder with enable, the next generation of the team's fixed 2-to-4/3-to-8 decoders. Two modes:
- **Direct:** loads an index through a valid/ready handshake.
- **Scan:** an internal counter steps through all outputs with a programmable dwell time.

It drives display-digit, row-select and chip-select strobes in the datapath.

Parameters:
- N, 3, select index width.
- OUTS, 8, number of one-hot outputs; must satisfy 2 <= OUTS <= 2**N.
- DWELL_W, 8, width of the dwell-time input and the internal dwell counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  global enable; when low, all outputs are forced to zero and state is frozen.
- mode  input  1  0 = direct mode, 1 = scan mode.
- load_valid  input  1  a direct-mode index is offered.
- load_idx  input  N  the offered index.
- load_ready  output  1  the block can accept a direct-mode load.
- dwell  input  DWELL_W  cycles minus one that each output stays selected in scan mode.
- y  output  OUTS  registered one-hot output.
- cur_idx  output  N  index currently held.
- wrap  output  1  one-cycle pulse when a scan wraps from OUTS-1 to 0.

Behaviour:
- **Reset** (rst_n low at a clock edge): y=0, cur_idx=0, wrap=0, load_ready=1, dwell counter=0, state=IDLE. Reset mid-scan or mid-load aborts the operation immediately.
- **States:**
  - IDLE (en=0).
  - DIRECT (en=1, mode=0).
  - SCAN (en=1, mode=1).
  - BLANK (only when the optional feature is compiled in).
  - State is re-evaluated every cycle from en and mode.
- **Output rule:** y = onehot(cur_idx) when en=1 and cur_idx < OUTS; otherwise y=0. y is registered, so a change is visible one cycle after the event that causes it.
- **IDLE:**
  - y=0 from the cycle after en falls.
  - cur_idx and the dwell counter hold their values.
  - load_ready=0; loads are ignored.
- **DIRECT:**
  - load_ready=1.
  - A transfer occurs when load_valid & load_ready are both high at a clock edge. cur_idx takes load_idx, and y shows the new index at the next edge (latency 1).
  - An out-of-range load (load_idx >= OUTS) is accepted: cur_idx is updated and y=0.
  - With no transfer, y holds.
- **SCAN:**
  - load_ready=0; load_valid is ignored.
  - The dwell counter increments each cycle.
  - When counter == dwell: counter clears and cur_idx advances by 1.
  - From OUTS-1 (or any out-of-range index), cur_idx advances to 0 and wrap pulses high for exactly one cycle, aligned with y showing index 0.
  - dwell=0 advances every cycle.
  - A change to dwell while scanning takes effect at the next compare.
- **Mode switch DIRECT→SCAN:** the dwell counter clears, and scanning starts from the current cur_idx.
- **Mode switch SCAN→DIRECT:** cur_idx holds; load_ready rises in the first DIRECT cycle.
- **en falling mid-scan:** the scan freezes; on re-enable it resumes with the preserved counter value.
- **Simultaneous events:** load_valid in the same cycle as a mode change to SCAN is ignored, because state is decided before the handshake.

Optional Feature:
- Macro: ONEHOT_SCAN_BLANK_EN.
- **Defined:** break-before-make. Every change of cur_idx (scan advance or a direct load of a different index) inserts one BLANK cycle:
  - y=0 and load_ready=0 during BLANK.
  - The new one-hot appears one cycle later, so direct latency is 2.
  - In scan mode the blank cycle counts as part of the dwell.
  - Reloading the same index causes no blank.
- **Undefined:** no BLANK state; transitions are immediate, as described above.

Decomposition:
- Package onehot_scan_pkg holds:
  - Localparams MODE_DIRECT=1'b0 and MODE_SCAN=1'b1.
  - State encodings ST_IDLE, ST_DIRECT, ST_SCAN, ST_BLANK.
- One natural sub-module: onehot_dec, a combinational N-to-OUTS decoder with enable and range check. It generalises the fixed-width decoders and is instantiated once for the y register input.

Test Plan:
1. **Reset:** hold rst_n=0 with en=1, mode=1 for 3 cycles → y=0, cur_idx=0, wrap=0, load_ready=1 throughout.
2. **Direct load:** N=3, OUTS=8, en=1, mode=0; load_valid=1, load_idx=5 for 1 cycle → next cycle y=8'b0010_0000, cur_idx=5. Then load_idx=7 → y=8'b1000_0000.
3. **Scan with dwell:** dwell=2, scan starting from idx 6 → y holds 0x40 for 3 cycles, then 0x80 for 3 cycles, then 0x01 with wrap=1 for exactly 1 cycle.
4. **Out-of-range:** OUTS=5, N=3; direct load of 6 → cur_idx=6, y=0. Then switch to scan → next advance gives idx 0, y=5'b00001, wrap=1.
5. **Enable freeze:** mid-scan at idx 3 with dwell counter=1, drop en for 4 cycles → y=0 and cur_idx stays 3. Raise en → idx 3 is shown again, then the scan advances after dwell-1 more cycles.
6. **Blank (ONEHOT_SCAN_BLANK_EN defined):** direct load 2 then 4 → y sequence 0x04, 0x00, 0x10, with load_ready=0 during the 0x00 cycle. Reload of 4 → no blank cycle.
